// File: rtl/awb_gain_ctrl_pkg.sv
// Shared constants and state encodings for the auto-white-balance gain controller.
package awb_pkg;

  localparam int          USER_SOF_BIT = 0;
  localparam int          USER_EOF_BIT = 1;
  localparam logic [15:0] UNITY_GAIN   = 16'h0100;

  typedef enum logic [1:0] {
    ACCUM,
    DIV_R,
    DIV_B,
    COMMIT_WAIT
  } awb_state_t;

  typedef enum logic [1:0] {
    DV_IDLE,
    DV_RUN,
    DV_ZERO
  } div_state_t;

endpackage

// File: rtl/awb_gain_ctrl_if.sv
// Pixel stream entering the ColorBlender; the gain controller only observes it.
interface awb_gain_ctrl_if #(
  parameter int DATA_WIDTH = 12
) ();

  logic [2:0][DATA_WIDTH-1:0] in_data;
  logic [7:0]                 in_user;
  logic                       in_valid;
  logic                       in_ready;

  modport master (
    output in_data,
    output in_user,
    output in_valid,
    output in_ready
  );

  modport slave (
    input in_data,
    input in_user,
    input in_valid,
    input in_ready
  );

endinterface

// File: rtl/awb_serial_div.sv
// Restoring serial divider: (num << FRAC_BITS) / den, one quotient bit per cycle,
// 16-bit saturating result; den == 0 finishes after one cycle with div_by_zero.
module awb_serial_div
  import awb_pkg::*;
#(
  parameter int SUM_WIDTH = 36,
  parameter int FRAC_BITS = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [SUM_WIDTH-1:0] num,
  input  logic [SUM_WIDTH-1:0] den,
  output logic                 done,
  output logic                 div_by_zero,
  output logic [15:0]          quotient
);

  localparam int NW = SUM_WIDTH + FRAC_BITS;
  localparam int CW = $clog2(NW + 1);

  div_state_t           state_q, state_d;
  logic [SUM_WIDTH-1:0] rem_q, rem_d;
  logic [SUM_WIDTH-1:0] den_q, den_d;
  logic [NW-1:0]        quo_q, quo_d;
  logic [NW-1:0]        quo_step;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [SUM_WIDTH:0]   rem_sh;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= DV_IDLE;
      rem_q   <= '0;
      den_q   <= '0;
      quo_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      den_q   <= den_d;
      quo_q   <= quo_d;
      cnt_q   <= cnt_d;
    end
  end

  // done and quotient are combinational on the final step so a new start can
  // be accepted in the same cycle, letting the caller chain divisions back to back.
  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    den_d       = den_q;
    quo_d       = quo_q;
    cnt_d       = cnt_q;
    done        = 1'b0;
    div_by_zero = 1'b0;
    rem_sh      = {rem_q, quo_q[NW-1]};
    quo_step    = quo_q;

    case (state_q)
      DV_RUN: begin
        if (rem_sh >= {1'b0, den_q}) begin
          rem_d    = rem_sh[SUM_WIDTH-1:0] - den_q;
          quo_step = {quo_q[NW-2:0], 1'b1};
        end else begin
          rem_d    = rem_sh[SUM_WIDTH-1:0];
          quo_step = {quo_q[NW-2:0], 1'b0};
        end
        quo_d = quo_step;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          done    = 1'b1;
          state_d = DV_IDLE;
        end
      end
      DV_ZERO: begin
        done        = 1'b1;
        div_by_zero = 1'b1;
        state_d     = DV_IDLE;
      end
      default: ;
    endcase

    quotient = (|quo_step[NW-1:16]) ? '1 : quo_step[15:0];

    if (start) begin
      rem_d   = '0;
      den_d   = den;
      quo_d   = {num, {FRAC_BITS{1'b0}}};
      cnt_d   = CW'(NW);
      state_d = (den == '0) ? DV_ZERO : DV_RUN;
    end
  end

endmodule

// File: rtl/awb_gain_ctrl.sv
// Gray-world AWB: snoops the blender input, sums channels per frame, divides
// G/R and G/B after EOF and commits the new gains at the following SOF.
module awb_gain_ctrl
  import awb_pkg::*;
#(
  parameter int          DATA_WIDTH = 12,
  parameter int          SUM_WIDTH  = 36,
  parameter int          SAT_THRESH = 4032,
  parameter logic [15:0] UNITY_GAIN = awb_pkg::UNITY_GAIN
) (
  input  logic                  clk,
  input  logic                  reset,
  awb_gain_ctrl_if.slave        pix,
  input  logic                  awb_enable,
  output logic [15:0]           gain_red,
  output logic [15:0]           gain_green,
  output logic [15:0]           gain_blue,
  output logic                  gains_updated,
  output logic                  busy,
  output logic                  stats_dropped
);

  awb_state_t                 state_q, state_d;
  logic [2:0][SUM_WIDTH-1:0]  sum_q, sum_d;
  logic [2:0][SUM_WIDTH-1:0]  snap_q, snap_d;
  logic [15:0]                gain_r_q, gain_r_d;
  logic [15:0]                gain_b_q, gain_b_d;
  logic [15:0]                pend_r_q, pend_r_d;
  logic [15:0]                pend_b_q, pend_b_d;
  logic                       pending_q, pending_d;
  logic                       upd_q, upd_d;
  logic                       drop_q, drop_d;
  logic                       launch_q, launch_d;

  logic                       beat, sof, eof, px_ok;
  logic [SUM_WIDTH-1:0]       acc_base;
  logic                       div_start, div_done, div_dz;
  logic [SUM_WIDTH-1:0]       div_den;
  logic [15:0]                div_quot;
  logic                       unused_user_bits;

  function automatic logic [SUM_WIDTH-1:0] sat_add(
    input logic [SUM_WIDTH-1:0]  a,
    input logic [DATA_WIDTH-1:0] p
  );
    logic [SUM_WIDTH:0] s;
    s = {1'b0, a} + {{(SUM_WIDTH + 1 - DATA_WIDTH){1'b0}}, p};
    return s[SUM_WIDTH] ? '1 : s[SUM_WIDTH-1:0];
  endfunction

  assign beat             = pix.in_valid & pix.in_ready;
  assign sof              = beat & pix.in_user[USER_SOF_BIT];
  assign eof              = beat & pix.in_user[USER_EOF_BIT];
  assign unused_user_bits = ^pix.in_user[7:2];

  always_comb begin
    px_ok = 1'b1;
    for (int unsigned i = 0; i < 3; i++) begin
      if (pix.in_data[i] >= DATA_WIDTH'(SAT_THRESH)) px_ok = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ACCUM;
      sum_q     <= '0;
      snap_q    <= '0;
      gain_r_q  <= UNITY_GAIN;
      gain_b_q  <= UNITY_GAIN;
      pend_r_q  <= '0;
      pend_b_q  <= '0;
      pending_q <= 1'b0;
      upd_q     <= 1'b0;
      drop_q    <= 1'b0;
      launch_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      sum_q     <= sum_d;
      snap_q    <= snap_d;
      gain_r_q  <= gain_r_d;
      gain_b_q  <= gain_b_d;
      pend_r_q  <= pend_r_d;
      pend_b_q  <= pend_b_d;
      pending_q <= pending_d;
      upd_q     <= upd_d;
      drop_q    <= drop_d;
      launch_q  <= launch_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    sum_d     = sum_q;
    snap_d    = snap_q;
    gain_r_d  = gain_r_q;
    gain_b_d  = gain_b_q;
    pend_r_d  = pend_r_q;
    pend_b_d  = pend_b_q;
    pending_d = pending_q;
    upd_d     = 1'b0;
    drop_d    = 1'b0;
    launch_d  = 1'b0;
    acc_base  = '0;
    div_start = launch_q;
    div_den   = (state_q == DIV_B) ? snap_q[0] : snap_q[2];

    if (beat) begin
      for (int unsigned i = 0; i < 3; i++) begin
        acc_base = sof ? '0 : sum_q[i];
        sum_d[i] = px_ok ? sat_add(acc_base, pix.in_data[i]) : acc_base;
      end
    end

    // The blue division is started in the cycle the red one completes.
    case (state_q)
      DIV_R: begin
        if (div_done) begin
          pend_r_d  = div_dz ? gain_r_q : div_quot;
          state_d   = DIV_B;
          div_start = 1'b1;
          div_den   = snap_q[0];
        end
      end
      DIV_B: begin
        if (div_done) begin
          pend_b_d  = div_dz ? gain_b_q : div_quot;
          state_d   = COMMIT_WAIT;
          pending_d = 1'b1;
        end
      end
      default: ;
    endcase

    if (sof) begin
      if (pending_q && (state_q == ACCUM || state_q == COMMIT_WAIT)) begin
        gain_r_d  = awb_enable ? pend_r_q : UNITY_GAIN;
        gain_b_d  = awb_enable ? pend_b_q : UNITY_GAIN;
        pending_d = 1'b0;
        upd_d     = 1'b1;
        state_d   = ACCUM;
      end else if (!pending_q && !awb_enable &&
                   (gain_r_q != UNITY_GAIN || gain_b_q != UNITY_GAIN)) begin
        gain_r_d = UNITY_GAIN;
        gain_b_d = UNITY_GAIN;
        upd_d    = 1'b1;
      end
    end

    if (eof) begin
      if (state_q == DIV_R || state_q == DIV_B) begin
        drop_d = 1'b1;
      end else begin
        snap_d   = sum_d;
        state_d  = DIV_R;
        launch_d = 1'b1;
      end
    end
  end

  awb_serial_div #(
    .SUM_WIDTH (SUM_WIDTH),
    .FRAC_BITS (8)
  ) u_div (
    .clk         (clk),
    .reset       (reset),
    .start       (div_start),
    .num         (snap_q[1]),
    .den         (div_den),
    .done        (div_done),
    .div_by_zero (div_dz),
    .quotient    (div_quot)
  );

  assign gain_red      = gain_r_q;
  assign gain_green    = UNITY_GAIN;
  assign gain_blue     = gain_b_q;
  assign gains_updated = upd_q;
  assign stats_dropped = drop_q;
  assign busy          = (state_q == DIV_R) || (state_q == DIV_B);

endmodule

// File: tb/tb_awb_gain_ctrl.sv
// Scoreboard bench for awb_gain_ctrl: expected gains are queued with each frame
// and popped by a monitor on every gains_updated pulse.
module tb_awb_gain_ctrl;

  localparam int DW = 12;
  localparam int SW = 36;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        awb_enable = 1'b1;
  logic [15:0] gain_red, gain_green, gain_blue;
  logic        gains_updated, busy, stats_dropped;

  awb_gain_ctrl_if #(.DATA_WIDTH(DW)) pix ();

  awb_gain_ctrl #(
    .DATA_WIDTH (DW),
    .SUM_WIDTH  (SW),
    .SAT_THRESH (4032),
    .UNITY_GAIN (16'h0100)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .pix           (pix),
    .awb_enable    (awb_enable),
    .gain_red      (gain_red),
    .gain_green    (gain_green),
    .gain_blue     (gain_blue),
    .gains_updated (gains_updated),
    .busy          (busy),
    .stats_dropped (stats_dropped)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] r;
    logic [15:0] b;
  } gexp_t;

  gexp_t exp_q[$];
  gexp_t exp_e;
  int    n_cmp = 0;
  int    n_mis = 0;
  int    pulses = 0;
  int    drops_seen = 0;
  int    drops_exp = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_mis++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (reset === 1'b0) begin
      if (gains_updated === 1'b1) begin
        pulses++;
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_mis++;
          $display("FAIL gains_updated_unexpected: pulse with red=%h blue=%h, none expected",
                   gain_red, gain_blue);
        end else begin
          exp_e = exp_q.pop_front();
          check("gain_red", gain_red, exp_e.r);
          check("gain_blue", gain_blue, exp_e.b);
          check("gain_green", gain_green, 16'h0100);
        end
      end
      if (stats_dropped === 1'b1) drops_seen++;
    end
  end

  task automatic drive(input logic [11:0] b, input logic [11:0] g, input logic [11:0] r,
                       input logic s, input logic e, input logic rdy);
    pix.in_data[0] = b;
    pix.in_data[1] = g;
    pix.in_data[2] = r;
    pix.in_user    = {6'b0, e, s};
    pix.in_valid   = 1'b1;
    pix.in_ready   = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    pix.in_valid = 1'b0;
    pix.in_ready = 1'b1;
    pix.in_user  = '0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic frame(input int n, input logic [11:0] b, input logic [11:0] g, input logic [11:0] r);
    for (int i = 0; i < n; i++) drive(b, g, r, i == 0, i == n - 1, 1'b1);
    idle(0);
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (busy === 1'b1 && k < 400) begin
      @(negedge clk);
      k++;
    end
    if (k >= 400) begin
      n_cmp++;
      n_mis++;
      $display("FAIL busy_timeout: busy still high after %0d cycles", k);
    end
    idle(2);
  endtask

  task automatic check_reset_state();
    check("reset_gain_red", gain_red, 16'h0100);
    check("reset_gain_blue", gain_blue, 16'h0100);
    check("reset_gain_green", gain_green, 16'h0100);
    check("reset_busy", busy, 0);
    check("reset_gains_updated", gains_updated, 0);
    check("reset_stats_dropped", stats_dropped, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int k;
    int p0;
    pix.in_data  = '0;
    pix.in_user  = '0;
    pix.in_valid = 1'b0;
    pix.in_ready = 1'b1;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_state();
    reset = 1'b0;
    idle(2);

    // F1 uniform 1000
    exp_q.push_back('{r: 16'h0100, b: 16'h0100});
    frame(16, 12'd1000, 12'd1000, 12'd1000);
    wait_idle();

    // F2 red sum zero: red keeps its current gain (unity after F1 commit)
    exp_q.push_back('{r: 16'h0100, b: 16'h0200});
    frame(16, 12'd400, 12'd800, 12'd0);
    wait_idle();

    // F3 G=1000 R=500 B=2000, busy duration bounded
    exp_q.push_back('{r: 16'h0200, b: 16'h0080});
    frame(16, 12'd2000, 12'd1000, 12'd500);
    k = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (busy !== 1'b1) break;
      k++;
    end
    n_cmp++;
    if (!(k > 0 && k <= 2 * (SW + 9))) begin
      n_mis++;
      $display("FAIL busy_cycles: got %0d, expected 1..%0d", k, 2 * (SW + 9));
    end
    wait_idle();

    // F4 saturated pixels excluded
    exp_q.push_back('{r: 16'h0100, b: 16'h0100});
    for (int i = 0; i < 16; i++)
      drive(12'd1000, 12'd1000, (i < 8) ? 12'd4095 : 12'd1000, i == 0, i == 15, 1'b1);
    idle(0);
    wait_idle();

    // F5 red quotient clamps
    exp_q.push_back('{r: 16'hFFFF, b: 16'h0100});
    frame(4, 12'd4000, 12'd4000, 12'd1);
    wait_idle();

    // F6 second EOF while dividing is dropped; first result still commits
    exp_q.push_back('{r: 16'h0100, b: 16'h0200});
    frame(4, 12'd500, 12'd1000, 12'd1000);
    idle(3);
    drive(12'd100, 12'd100, 12'd100, 1'b1, 1'b0, 1'b1);
    idle(5);
    drops_exp++;
    drive(12'd100, 12'd100, 12'd100, 1'b0, 1'b1, 1'b1);
    idle(0);
    wait_idle();

    // F7 stalled SOF/EOF cycles are not beats
    exp_q.push_back('{r: 16'h0400, b: 16'h0100});
    repeat (3) drive(12'd2000, 12'd2000, 12'd2000, 1'b1, 1'b0, 1'b0);
    drive(12'd1000, 12'd1000, 12'd250, 1'b1, 1'b0, 1'b1);
    repeat (2) drive(12'd1000, 12'd1000, 12'd250, 1'b0, 1'b0, 1'b1);
    repeat (3) drive(12'd2000, 12'd2000, 12'd2000, 1'b0, 1'b1, 1'b0);
    drive(12'd1000, 12'd1000, 12'd250, 1'b0, 1'b1, 1'b1);
    idle(0);
    wait_idle();

    // F8 reset during DIV_R aborts the division
    frame(4, 12'd2000, 12'd1000, 12'd500);
    idle(5);
    check("busy_before_reset", busy, 1);
    reset = 1'b1;
    idle(2);
    check_reset_state();
    reset = 1'b0;
    idle(1);

    // F9 enable off, nothing pending: no pulse; later pending commit forced to unity
    awb_enable = 1'b0;
    p0 = pulses;
    frame(4, 12'd2000, 12'd1000, 12'd500);
    idle(2);
    check("no_update_after_reset", pulses, p0);
    wait_idle();
    exp_q.push_back('{r: 16'h0100, b: 16'h0100});
    drive(12'd10, 12'd10, 12'd10, 1'b1, 1'b0, 1'b1);
    idle(3);
    awb_enable = 1'b1;

    // F10 one-pixel frame (SOF and EOF on the same beat)
    exp_q.push_back('{r: 16'h0200, b: 16'h0080});
    drive(12'd200, 12'd100, 12'd50, 1'b1, 1'b1, 1'b1);
    idle(0);
    wait_idle();
    drive(12'd10, 12'd10, 12'd10, 1'b1, 1'b0, 1'b1);
    idle(4);

    check("expectations_left", exp_q.size(), 0);
    check("stats_dropped_count", drops_seen, drops_exp);
    check("gains_updated_count", pulses, 9);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/awb_gain_ctrl.md
Name: awb_gain_ctrl

Overview:
- Gray-world auto-white-balance controller for the ColorBlender stage. It snoops the 3-channel pixel stream entering the blender and accumulates per-channel sums over each frame.
- After end of frame it computes red and blue gains relative to green with a serial divider.
- It drives gain_red / gain_green / gain_blue into the blender, applying new values only at the next start-of-frame so the gains never change mid-frame.

Parameters:
- DATA_WIDTH, 12, input pixel bit depth per channel.
- SUM_WIDTH, 36, per-channel accumulator width; sized for 4096x4096 pixels at 12 bits.
- SAT_THRESH, 4032, a pixel is excluded if any channel is >= this value.
- UNITY_GAIN, 16'h0100, gain value meaning x1 in the blender (12-bit in, 8-bit out).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- in_data  in  DATA_WIDTH x3  pixel channels; [0]=B, [1]=G, [2]=R
- in_user  in  8  sideband; bit0 = SOF (first beat of frame), bit1 = EOF (last beat of frame)
- in_valid  in  1  upstream valid (snooped)
- in_ready  in  1  blender out_ready (snooped); beat = in_valid & in_ready
- awb_enable  in  1  1 = automatic gains; 0 = force all gains to UNITY_GAIN at the next SOF
- gain_red  out  16  red gain to blender
- gain_green  out  16  green gain; always UNITY_GAIN
- gain_blue  out  16  blue gain to blender
- gains_updated  out  1  one-cycle pulse on the cycle the gain outputs change
- busy  out  1  high while the divider runs (states DIV_R, DIV_B)
- stats_dropped  out  1  one-cycle pulse when a frame's statistics are discarded

Behaviour:
- Reset: gains = UNITY_GAIN; gains_updated = 0, busy = 0, stats_dropped = 0; accumulators and snapshots cleared; state = ACCUM; pending = 0.
- Passive snoop only. The block never stalls the stream and only samples on a beat.
- Accumulation:
  - A beat with SOF clears all three sums, then adds that beat's pixel in the same cycle.
  - Any other beat adds its pixel.
  - A pixel is added only if all three channels are < SAT_THRESH.
  - Sums saturate at all-ones and never wrap.
- EOF beat:
  - The sums including the EOF pixel are copied into snapshot registers S_B, S_G, S_R.
  - State goes to DIV_R, provided the state is ACCUM or COMMIT_WAIT.
  - If the state is DIV_R or DIV_B, the snapshot is not taken and stats_dropped pulses.
  - A single beat with both SOF and EOF counts as a one-pixel frame: clear, add, then snapshot.
- DIV_R: restoring divider computes (S_G << 8) / S_R.
  - Numerator is SUM_WIDTH+8 bits; takes SUM_WIDTH+8 cycles plus 1 setup cycle.
  - Quotient > 16'hFFFF clamps to 16'hFFFF.
  - S_R == 0: the result is the current gain_red; the divider is skipped and takes 1 cycle.
- DIV_B: same computation with S_B; result goes to pending_b. Then state = COMMIT_WAIT and pending = 1.
- COMMIT_WAIT / ACCUM, on the next SOF beat with pending = 1:
  - Load gain_red/gain_blue from pending_r/pending_b, or UNITY_GAIN if awb_enable = 0.
  - Set pending = 0, pulse gains_updated for one cycle, state = ACCUM.
  - Gains update the cycle after the SOF beat. The SOF pixel itself is processed with the old gains, because the blender registers its gains one cycle later.
- An SOF arriving during DIV_R/DIV_B restarts accumulation normally. The division continues unaffected and its result commits at the following SOF.
- awb_enable = 0 with no pending result: gains go to UNITY_GAIN at the next SOF, with a gains_updated pulse only if the value changed.
- Reset mid-division aborts it; pending is cleared and no pulse is generated.
- gain_green is constant UNITY_GAIN.

Decomposition:
- Package awb_pkg:
  - constants USER_SOF_BIT = 0, USER_EOF_BIT = 1, UNITY_GAIN;
  - enum typedef awb_state_t {ACCUM, DIV_R, DIV_B, COMMIT_WAIT}.
- One sub-module, awb_serial_div: parameterised restoring divider with start, done, a divide-by-zero flag and a 16-bit saturating quotient. It is instantiated once and reused for R then B.

Test Plan:
- Uniform frame, 16 pixels, B=G=R=1000, then SOF -> gain_red = gain_blue = 16'h0100; gains_updated pulses once.
- 16 pixels with G=1000, R=500, B=2000, then SOF -> gain_red = 16'h0200, gain_blue = 16'h0080; busy high for at most 2*(SUM_WIDTH+9) cycles after EOF.
- Frame with R=0 everywhere and G=800 -> gain_red unchanged (16'h0100); gain_blue computed normally.
- Frame with half the pixels at R=4095 (saturated) and half at R=G=B=1000 -> saturated pixels excluded; gains = 16'h0100.
- G=4000, R=1 over 4 pixels -> gain_red clamps to 16'hFFFF.
- Second EOF beat issued 10 cycles after the first EOF (divider busy) -> stats_dropped pulses; first result still commits at the next SOF.
- in_valid=1 with in_ready=0 on SOF/EOF beats -> no accumulation or snapshot until in_ready=1.
- Assert reset during DIV_R -> all outputs return to reset values; no gains_updated pulse at the next SOF.
